// File: rtl/seq_shift_add_multplr_pkg.sv
// Shared definitions for the sequential arithmetic blocks: FSM state
// encoding and the counter-width helper.
package seq_shift_add_multplr_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_t;

  // Smallest r with 2**r >= n; sizes iteration counters (called with WIDTH+1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/seq_shift_add_multplr_adder.sv
// Ripple-carry adder with carry out, built from the full_adder cell.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module n_bit_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_shift_add_multplr.sv
// Sequential shift-add multiplier: one WIDTH-bit adder, WIDTH iterations,
// start/done handshake, unsigned or two's-complement operands per operation.
// Signed operands are reduced to magnitudes at load and the sign is
// reapplied when the product is written.

module seq_shift_add_multplr
  import seq_shift_add_multplr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = clog2(WIDTH + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;      // multiplicand magnitude
  logic [2*WIDTH-1:0] acc;        // {partial product, remaining multiplier bits}
  logic               neg;        // result sign for signed mode
  logic               load;
  logic               last_step;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH-1:0] acc_nxt;

  // Magnitude of a two's-complement operand; -2**(WIDTH-1) maps to
  // 2**(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sm);
    return (sm && v[WIDTH-1]) ? -v : v;
  endfunction

  assign last_step = (state == CALC) && (cnt == CNT_W'(WIDTH - 1));

  // Add the multiplicand when the current multiplier bit is set; the carry
  // out becomes the top bit of the right-shifted accumulator.
  assign addend  = mcand & {WIDTH{acc[0]}};
  assign acc_nxt = {carry, sum, acc[WIDTH-1:1]};

  n_bit_adder #(.WIDTH(WIDTH)) u_adder (
    .a   (acc[2*WIDTH-1:WIDTH]),
    .b   (addend),
    .cin (1'b0),
    .sum (sum),
    .cout(carry)
  );

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done  = 1'b1;
        ready = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand load, one shift-add step per CALC cycle, sign fix on write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      mcand   <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (load) begin
      cnt   <= '0;
      mcand <= mag(b, signed_mode);
      acc   <= {{WIDTH{1'b0}}, mag(a, signed_mode)};
      neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      acc <= acc_nxt;
      if (last_step) product <= neg ? -acc_nxt : acc_nxt;
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multplr.sv
// Self-checking bench for seq_shift_add_multplr at WIDTH=4 and WIDTH=8.
// Expected products are pushed when an operation is started and compared,
// together with the done cycle, when done pulses.

module tb_seq_shift_add_multplr;

  logic clk = 1'b0;
  logic rst;

  logic        start4, sm4, ready4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  prod4;

  logic        start8, sm8, ready8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  seq_shift_add_multplr #(.WIDTH(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .start      (start4),
    .signed_mode(sm4),
    .a          (a4),
    .b          (b4),
    .ready      (ready4),
    .busy       (busy4),
    .done       (done4),
    .product    (prod4)
  );

  seq_shift_add_multplr #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .start      (start8),
    .signed_mode(sm8),
    .a          (a8),
    .b          (b8),
    .ready      (ready8),
    .busy       (busy8),
    .done       (done8),
    .product    (prod8)
  );

  always #5 clk = ~clk;

  // Count of rising edges so far; read only on falling edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] exp;
    int          due;   // value of cyc at the falling edge where done is expected
  } sb_t;

  sb_t q4[$];
  sb_t q8[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] model4(input logic sm, input logic [3:0] x, input logic [3:0] y);
    logic [7:0] ex, ey;
    ex = sm ? {{4{x[3]}}, x} : {4'b0, x};
    ey = sm ? {{4{y[3]}}, y} : {4'b0, y};
    return ex * ey;
  endfunction

  function automatic logic [15:0] model8(input logic sm, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] ex, ey;
    ex = sm ? {{8{x[7]}}, x} : {8'b0, x};
    ey = sm ? {{8{y[7]}}, y} : {8'b0, y};
    return ex * ey;
  endfunction

  // Scoreboard side, WIDTH=4: product, done cycle, one-cycle pulse.
  logic done4_d = 1'b0;
  always @(negedge clk) begin
    sb_t e;
    if (done4) begin
      if (q4.size() == 0) check("done4_unexpected", 1, 0);
      else begin
        e = q4.pop_front();
        check("prod4", prod4, e.exp);
        check("lat4", cyc, e.due);
      end
    end
    if (done4 && done4_d) check("done4_pulse", 1, 0);
    done4_d = done4;
  end

  // Scoreboard side, WIDTH=8.
  logic done8_d = 1'b0;
  always @(negedge clk) begin
    sb_t e;
    if (done8) begin
      if (q8.size() == 0) check("done8_unexpected", 1, 0);
      else begin
        e = q8.pop_front();
        check("prod8", prod8, e.exp);
        check("lat8", cyc, e.due);
      end
    end
    if (done8 && done8_d) check("done8_pulse", 1, 0);
    done8_d = done8;
  end

  // Start one WIDTH=4 operation when ready; inputs are scrambled afterwards
  // so a result depending on post-load values would be wrong.
  task automatic op4(input logic sm, input logic [3:0] x, input logic [3:0] y);
    sb_t e;
    int  n;
    n = 0;
    @(negedge clk);
    while (!ready4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready4) begin
      check("ready4_timeout", 0, 1);
      return;
    end
    start4 = 1'b1; sm4 = sm; a4 = x; b4 = y;
    e.exp = 16'(model4(sm, x, y));
    e.due = cyc + 1 + 4;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0; sm4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
  endtask

  task automatic op8(input logic sm, input logic [7:0] x, input logic [7:0] y);
    sb_t e;
    int  n;
    n = 0;
    @(negedge clk);
    while (!ready8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready8) begin
      check("ready8_timeout", 0, 1);
      return;
    end
    start8 = 1'b1; sm8 = sm; a8 = x; b8 = y;
    e.exp = model8(sm, x, y);
    e.due = cyc + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0; sm8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  // Wait, bounded, for every outstanding result to come back.
  task automatic drain();
    int n;
    n = 0;
    while ((q4.size() != 0 || q8.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", q4.size() + q8.size(), 0);
  endtask

  logic [3:0] b2b_a[4]  = '{4'd7, 4'b1001, 4'hF, 4'b0111};
  logic [3:0] b2b_b[4]  = '{4'd9, 4'b0011, 4'h1, 4'b1000};
  logic       b2b_sm[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    sb_t e;
    rst = 1'b1;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_ready4", ready4, 1);
    check("rst_busy4",  busy4,  0);
    check("rst_done4",  done4,  0);
    check("rst_prod4",  prod4,  0);
    check("rst_ready8", ready8, 1);
    check("rst_busy8",  busy8,  0);
    check("rst_prod8",  prod8,  0);

    // Directed WIDTH=4 cases: 15*15, -8*-8, -3*5, 13*5.
    op4(1'b0, 4'd15, 4'd15);
    op4(1'b1, 4'b1000, 4'b1000);
    op4(1'b1, 4'b1101, 4'b0101);
    op4(1'b0, 4'b1101, 4'b0101);
    drain();

    // start held high, operands scrambled every CALC cycle; each new
    // operation is accepted from DONE, so done recurs every 5 cycles.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_ready", ready4, 1);
      start4 = 1'b1; sm4 = b2b_sm[i]; a4 = b2b_a[i]; b4 = b2b_b[i];
      e.exp = 16'(model4(b2b_sm[i], b2b_a[i], b2b_b[i]));
      e.due = cyc + 1 + 4;
      q4.push_back(e);
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        sm4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
      end
    end
    @(negedge clk);
    start4 = 1'b0;
    drain();

    // Reset in the second CALC cycle: abort with no done, product cleared.
    @(negedge clk);
    start4 = 1'b1; sm4 = 1'b0; a4 = 4'd9; b4 = 4'd7;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    check("mid_busy4",  busy4,  1);
    check("mid_ready4", ready4, 0);
    rst = 1'b1;
    #1;
    check("abort_ready4", ready4, 1);
    check("abort_busy4",  busy4,  0);
    check("abort_done4",  done4,  0);
    check("abort_prod4",  prod4,  0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    op4(1'b0, 4'd9, 4'd7);
    drain();

    // Directed WIDTH=8 cases: 255*255, -128*127, zero operands.
    op8(1'b0, 8'd255, 8'd255);
    op8(1'b1, 8'h80, 8'h7F);
    op8(1'b0, 8'h00, 8'hA5);
    op8(1'b1, 8'h80, 8'h00);
    op8(1'b1, 8'h80, 8'h80);
    drain();

    // Random sweep, both widths and both modes, interleaved.
    for (int i = 0; i < 24; i++) begin
      op4(1'(i), 4'($urandom), 4'($urandom));
      op8(1'(i >> 1), 8'($urandom), 8'($urandom));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
